// File: rtl/dac_mux_pkg.sv
// Shared types and default parameters for the multiplexed serial DAC scanner.
package dac_mux_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_N_CH   = 6;
  localparam int DEF_HALF   = 2;
  localparam int DEF_LD_GAP = 2;
  localparam int DEF_LD_W   = 2;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_CLR_W  = 2;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_SHIFT, ST_GAP, ST_LOAD, ST_SETTLE
  } state_t;

  // clog2 that never yields a zero-width vector
  function automatic int clog2_1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dac_mux_scanner_if.sv
// Control/write port and DAC/mux outputs of the scanner, grouped as one bus.
interface dac_mux_scanner_if #(
  parameter int DATA_W = dac_mux_pkg::DEF_DATA_W,
  parameter int N_CH   = dac_mux_pkg::DEF_N_CH
);
  localparam int CHW = dac_mux_pkg::clog2_1(N_CH);

  logic              start;
  logic              cont;
  logic              clr_req;
  logic              wr_en;
  logic [CHW-1:0]    wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              dac_clk;
  logic              dac_sdi;
  logic              dac_ld_n;
  logic              dac_clr_n;
  logic [N_CH-1:0]   mux_sel;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, cont, clr_req, wr_en, wr_ch, wr_data,
    input  dac_clk, dac_sdi, dac_ld_n, dac_clr_n, mux_sel, busy, frame_done
  );
  modport slave (
    input  start, cont, clr_req, wr_en, wr_ch, wr_data,
    output dac_clk, dac_sdi, dac_ld_n, dac_clr_n, mux_sel, busy, frame_done
  );
endinterface

// File: rtl/dac_bit_shifter.sv
// Serializes one DAC code MSB first: latches on load, then 2*HALF cycles per bit,
// dac_clk low for the first HALF cycles and high for the last HALF.
module dac_bit_shifter import dac_mux_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HALF   = DEF_HALF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              dac_clk,
  output logic              dac_sdi,
  output logic              last
);
  localparam int DW = clog2_1(2 * HALF);
  localparam int BW = clog2_1(DATA_W);

  logic [DATA_W-1:0] sr;
  logic [DW-1:0]     div;
  logic [BW-1:0]     bitcnt;
  logic              run;
  logic              bit_end;

  assign bit_end = (div == DW'(2 * HALF - 1));
  assign last    = run && bit_end && (bitcnt == BW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      div     <= '0;
      bitcnt  <= '0;
      run     <= 1'b0;
      dac_clk <= 1'b1;
      dac_sdi <= 1'b0;
    end else begin
      // outputs trail the divider by one cycle so they come straight from flops
      if (run) begin
        dac_clk <= (div >= DW'(HALF));
        dac_sdi <= sr[DATA_W-1];
      end else begin
        dac_clk <= 1'b1;
        dac_sdi <= 1'b0;
      end
      if (load) begin
        sr     <= din;
        div    <= '0;
        bitcnt <= '0;
        run    <= 1'b1;
      end else if (run) begin
        if (bit_end) begin
          div    <= '0;
          sr     <= sr << 1;
          bitcnt <= bitcnt + 1'b1;
          if (last) run <= 1'b0;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dac_mux_scanner.sv
// Scans a bank of DAC codes over N_CH mux channels: shift, load, then hold the
// analog mux on the channel while it settles. Optional DAC clear between channels.
module dac_mux_scanner import dac_mux_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH,
  parameter int HALF   = DEF_HALF,
  parameter int LD_GAP = DEF_LD_GAP,
  parameter int LD_W   = DEF_LD_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CLR_W  = DEF_CLR_W
) (
  input  logic               clk,
  input  logic               reset,
  dac_mux_scanner_if.slave   bus
);
  localparam int CHW = clog2_1(N_CH);

  state_t            st, st_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [CHW-1:0]    ch, ch_d;
  logic              rs, rs_d;
  logic              clr_pend, clr_take;
  logic              load, fd, go, last_ch, sh_last, wr_ok;
  logic [DATA_W-1:0] bank [N_CH];
  logic [DATA_W-1:0] sh_din;

  assign last_ch = (ch == CHW'(N_CH - 1));
  assign wr_ok   = bus.wr_en && ({1'b0, bus.wr_ch} < (CHW + 1)'(N_CH));
  // latched at the SHIFT-entry edge, so a write on that same edge lands next visit
  assign sh_din  = bank[ch_d];

  always_comb begin
    st_d     = st;
    cnt_d    = cnt + 1'b1;
    ch_d     = ch;
    rs_d     = rs;
    clr_take = 1'b0;
    load     = 1'b0;
    fd       = 1'b0;
    go       = 1'b0;
    case (st)
      ST_IDLE: begin
        cnt_d = '0;
        if (clr_pend) begin
          st_d     = ST_CLEAR;
          clr_take = 1'b1;
          rs_d     = 1'b0;
        end else if (bus.start) begin
          st_d = ST_SHIFT;
          ch_d = '0;
          load = 1'b1;
        end
      end
      ST_CLEAR: if (cnt == CNT_W'(CLR_W - 1)) begin
        cnt_d = '0;
        if (rs) begin
          st_d = ST_SHIFT;
          load = 1'b1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        cnt_d = '0;
        if (sh_last) st_d = ST_GAP;
      end
      ST_GAP: if (cnt == CNT_W'(LD_GAP - 1)) begin
        cnt_d = '0;
        st_d  = ST_LOAD;
      end
      ST_LOAD: if (cnt == CNT_W'(LD_W - 1)) begin
        cnt_d = '0;
        st_d  = ST_SETTLE;
      end
      ST_SETTLE: if (cnt == CNT_W'(SETTLE - 1)) begin
        cnt_d = '0;
        fd    = last_ch;
        ch_d  = last_ch ? '0 : ch + 1'b1;
        go    = !last_ch || bus.cont;
        // a pending clear slots in here; rs remembers whether to resume shifting
        if (clr_pend) begin
          st_d     = ST_CLEAR;
          clr_take = 1'b1;
          rs_d     = go;
        end else if (go) begin
          st_d = ST_SHIFT;
          load = 1'b1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st             <= ST_IDLE;
      cnt            <= '0;
      ch             <= '0;
      rs             <= 1'b0;
      clr_pend       <= 1'b0;
      for (int i = 0; i < N_CH; i++) bank[i] <= '0;
      bus.dac_ld_n   <= 1'b1;
      bus.dac_clr_n  <= 1'b1;
      bus.mux_sel    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      st       <= st_d;
      cnt      <= cnt_d;
      ch       <= ch_d;
      rs       <= rs_d;
      clr_pend <= (clr_pend && !clr_take) || bus.clr_req;
      if (wr_ok) bank[bus.wr_ch] <= bus.wr_data;
      bus.dac_ld_n   <= (st != ST_LOAD);
      bus.dac_clr_n  <= (st != ST_CLEAR);
      bus.mux_sel    <= (st == ST_SETTLE) ? (N_CH'(1) << ch) : '0;
      bus.busy       <= (st != ST_IDLE);
      bus.frame_done <= fd;
    end
  end

  dac_bit_shifter #(.DATA_W(DATA_W), .HALF(HALF)) u_sh (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (sh_din),
    .dac_clk (bus.dac_clk),
    .dac_sdi (bus.dac_sdi),
    .last    (sh_last)
  );
endmodule

// File: tb/tb_dac_mux_scanner.sv
// Bench for dac_mux_scanner: default instance plus a 16-bit/2-channel/HALF=1 instance.
module tb_dac_mux_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  dac_mux_scanner_if #(.DATA_W(12), .N_CH(6)) ba();
  dac_mux_scanner_if #(.DATA_W(16), .N_CH(2)) bb();

  dac_mux_scanner dut_a (.clk(clk), .reset(reset), .bus(ba));
  dac_mux_scanner #(.DATA_W(16), .N_CH(2), .HALF(1)) dut_b (.clk(clk), .reset(reset), .bus(bb));

  typedef struct {int ch; logic [15:0] w;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [11:0] ma [6];
  logic [15:0] mb [2];

  // channel-visit monitors: deserialize sdi on dac_clk rises, compare at mux_sel rise
  logic pclk_a, pld_a, pclr_a, pclk_b, pld_b;
  logic [5:0] pmux_a;
  logic [1:0] pmux_b;
  logic [15:0] word_a, word_b;
  int nb_a, sdi_hi_a, ld_cnt_a, ld_fall_a, ld_len_a, clr_cnt_a, clr_fall_a, clr_len_a;
  int mux_len_a, fd_cnt_a, fd_cyc_a;
  int nb_b, ld_len_b, mux_len_b, fd_cnt_b, fd_cyc_b, rise_b, prise_b;

  initial begin
    sdi_hi_a = 0; ld_cnt_a = 0; clr_cnt_a = 0; fd_cnt_a = 0; fd_cnt_b = 0;
    ld_fall_a = 0; clr_fall_a = 0; fd_cyc_a = 0; fd_cyc_b = 0; rise_b = 0; prise_b = 0;
  end

  always @(negedge clk) begin
    if (reset) begin
      pclk_a = 1'b1; pld_a = 1'b1; pclr_a = 1'b1; pmux_a = '0; word_a = '0; nb_a = 0;
    end else begin
      if (!pclk_a && ba.dac_clk) begin word_a = {word_a[14:0], ba.dac_sdi}; nb_a++; end
      if (ba.dac_sdi) sdi_hi_a++;
      if (pld_a && !ba.dac_ld_n) begin ld_cnt_a++; ld_fall_a = cyc; ld_len_a = 0; end
      if (!ba.dac_ld_n) ld_len_a++;
      if (!pld_a && ba.dac_ld_n) begin
        n_chk++;
        if (ld_len_a != 2) begin n_fail++; $display("FAIL ld_width_a: got %0d cycles, want 2", ld_len_a); end
      end
      if (pclr_a && !ba.dac_clr_n) begin clr_cnt_a++; clr_fall_a = cyc; clr_len_a = 0; end
      if (!ba.dac_clr_n) clr_len_a++;
      if (!pclr_a && ba.dac_clr_n) begin
        n_chk++;
        if (clr_len_a != 2) begin n_fail++; $display("FAIL clr_width_a: got %0d cycles, want 2", clr_len_a); end
      end
      if (pmux_a == '0 && ba.mux_sel != '0) begin
        mux_len_a = 0;
        n_chk++;
        if (qa.size() == 0) begin
          n_fail++; $display("FAIL sb_a_empty: unexpected visit mux_sel=%b", ba.mux_sel);
        end else begin
          ea = qa.pop_front();
          if (ba.mux_sel !== 6'(1 << ea.ch) || word_a[11:0] !== ea.w[11:0] || nb_a != 12) begin
            n_fail++;
            $display("FAIL sb_a_visit: got mux=%b word=%h bits=%0d, want mux=%b word=%h bits=12",
                     ba.mux_sel, word_a[11:0], nb_a, 6'(1 << ea.ch), ea.w[11:0]);
          end
        end
        word_a = '0; nb_a = 0;
      end
      if (ba.mux_sel != '0) mux_len_a++;
      if (pmux_a != '0 && ba.mux_sel == '0) begin
        n_chk++;
        if (mux_len_a != 4) begin n_fail++; $display("FAIL settle_a: got %0d cycles, want 4", mux_len_a); end
      end
      if (ba.frame_done) begin fd_cnt_a++; fd_cyc_a = cyc; end
      pclk_a = ba.dac_clk; pld_a = ba.dac_ld_n; pclr_a = ba.dac_clr_n; pmux_a = ba.mux_sel;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      pclk_b = 1'b1; pld_b = 1'b1; pmux_b = '0; word_b = '0; nb_b = 0;
    end else begin
      if (!pclk_b && bb.dac_clk) begin word_b = {word_b[14:0], bb.dac_sdi}; nb_b++; end
      if (pld_b && !bb.dac_ld_n) ld_len_b = 0;
      if (!bb.dac_ld_n) ld_len_b++;
      if (!pld_b && bb.dac_ld_n) begin
        n_chk++;
        if (ld_len_b != 2) begin n_fail++; $display("FAIL ld_width_b: got %0d cycles, want 2", ld_len_b); end
      end
      if (pmux_b == '0 && bb.mux_sel != '0) begin
        prise_b = rise_b; rise_b = cyc; mux_len_b = 0;
        n_chk++;
        if (qb.size() == 0) begin
          n_fail++; $display("FAIL sb_b_empty: unexpected visit mux_sel=%b", bb.mux_sel);
        end else begin
          eb = qb.pop_front();
          if (bb.mux_sel !== 2'(1 << eb.ch) || word_b !== eb.w || nb_b != 16) begin
            n_fail++;
            $display("FAIL sb_b_visit: got mux=%b word=%h bits=%0d, want mux=%b word=%h bits=16",
                     bb.mux_sel, word_b, nb_b, 2'(1 << eb.ch), eb.w);
          end
        end
        word_b = '0; nb_b = 0;
      end
      if (bb.mux_sel != '0) mux_len_b++;
      if (pmux_b != '0 && bb.mux_sel == '0) begin
        n_chk++;
        if (mux_len_b != 4) begin n_fail++; $display("FAIL settle_b: got %0d cycles, want 4", mux_len_b); end
      end
      if (bb.frame_done) begin fd_cnt_b++; fd_cyc_b = cyc; end
      pclk_b = bb.dac_clk; pld_b = bb.dac_ld_n; pmux_b = bb.mux_sel;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int c, input logic [11:0] d);
    ba.wr_en = 1'b1; ba.wr_ch = 3'(c); ba.wr_data = d;
    tick(1);
    ba.wr_en = 1'b0;
    if (c < 6) ma[c] = d;
  endtask

  task automatic wr_b(input int c, input logic [15:0] d);
    bb.wr_en = 1'b1; bb.wr_ch = 1'(c); bb.wr_data = d;
    tick(1);
    bb.wr_en = 1'b0;
    mb[c] = d;
  endtask

  task automatic push_a();
    exp_t e;
    for (int c = 0; c < 6; c++) begin e.ch = c; e.w = 16'(ma[c]); qa.push_back(e); end
  endtask

  task automatic go_a(input logic c, output int t0);
    push_a();
    ba.start = 1'b1; ba.cont = c;
    tick(1);
    t0 = cyc;
    ba.start = 1'b0;
  endtask

  task automatic wait_fd_a(input int target, input int lim);
    for (int i = 0; i < lim && fd_cnt_a < target; i++) tick(1);
  endtask

  task automatic test_reset();
    tick(3);
    n_chk++;
    if ({ba.dac_clk, ba.dac_sdi, ba.dac_ld_n, ba.dac_clr_n, ba.busy, ba.frame_done, ba.mux_sel} !== 12'b101100_000000) begin
      n_fail++; $display("FAIL reset_a: got %b, want 101100000000",
        {ba.dac_clk, ba.dac_sdi, ba.dac_ld_n, ba.dac_clr_n, ba.busy, ba.frame_done, ba.mux_sel});
    end
    reset = 1'b0;
    tick(3);
    n_chk++;
    if ({bb.dac_clk, bb.dac_sdi, bb.dac_ld_n, bb.dac_clr_n, bb.busy, bb.frame_done, bb.mux_sel} !== 8'b101100_00) begin
      n_fail++; $display("FAIL idle_b: got %b, want 10110000",
        {bb.dac_clk, bb.dac_sdi, bb.dac_ld_n, bb.dac_clr_n, bb.busy, bb.frame_done, bb.mux_sel});
    end
  endtask

  task automatic test_single_frame();
    int t0, l0, f0;
    wr_a(0, 12'h555);
    for (int c = 1; c < 6; c++) wr_a(c, 12'($urandom_range(0, 4095)));
    l0 = ld_cnt_a; f0 = fd_cnt_a;
    go_a(1'b0, t0);
    n_chk++;
    if (ba.dac_clk !== 1'b1) begin n_fail++; $display("FAIL clk_cycle0: got %b, want 1", ba.dac_clk); end
    tick(1);
    n_chk++;
    if ({ba.dac_clk, ba.dac_sdi, ba.busy} !== 3'b001) begin
      n_fail++; $display("FAIL first_bit: got clk/sdi/busy=%b, want 001", {ba.dac_clk, ba.dac_sdi, ba.busy});
    end
    tick(4);
    n_chk++;
    if ({ba.dac_clk, ba.dac_sdi} !== 2'b01) begin
      n_fail++; $display("FAIL second_bit: got clk/sdi=%b, want 01", {ba.dac_clk, ba.dac_sdi});
    end
    for (int i = 0; i < 100 && ld_cnt_a == l0; i++) tick(1);
    n_chk++;
    if (ld_fall_a - t0 != 51) begin n_fail++; $display("FAIL ld_timing: got cycle %0d, want 51", ld_fall_a - t0); end
    wait_fd_a(f0 + 1, 1000);
    n_chk++;
    if (fd_cnt_a != f0 + 1 || fd_cyc_a - t0 != 336) begin
      n_fail++; $display("FAIL frame_done_single: got count %0d at cycle %0d, want 1 at 336", fd_cnt_a - f0, fd_cyc_a - t0);
    end
    n_chk++;
    if ({ba.busy, ba.frame_done} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_frame: got busy/fd=%b, want 00", {ba.busy, ba.frame_done});
    end
    tick(8);
    n_chk++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL sb_drain_single: %0d visits missing, want 0", qa.size()); end
  endtask

  task automatic test_bank3();
    int t0, h0, f0;
    for (int c = 0; c < 6; c++) wr_a(c, (c == 3) ? 12'hFFF : 12'h000);
    wr_a(6, 12'hABC);
    wr_a(7, 12'h123);
    h0 = sdi_hi_a; f0 = fd_cnt_a;
    go_a(1'b0, t0);
    tick(221);
    n_chk++;
    if (ba.mux_sel !== 6'b001000) begin n_fail++; $display("FAIL mux_ch3_start: got %b, want 001000", ba.mux_sel); end
    tick(3);
    n_chk++;
    if (ba.mux_sel !== 6'b001000) begin n_fail++; $display("FAIL mux_ch3_end: got %b, want 001000", ba.mux_sel); end
    tick(1);
    n_chk++;
    if (ba.mux_sel !== 6'b000000) begin n_fail++; $display("FAIL mux_ch3_off: got %b, want 000000", ba.mux_sel); end
    wait_fd_a(f0 + 1, 1000);
    tick(8);
    n_chk++;
    if (sdi_hi_a - h0 != 48) begin n_fail++; $display("FAIL sdi_high_cycles: got %0d, want 48", sdi_hi_a - h0); end
    n_chk++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL sb_drain_bank3: %0d visits missing, want 0", qa.size()); end
  endtask

  task automatic test_clear();
    int t0, c0, f0;
    c0 = clr_cnt_a; f0 = fd_cnt_a;
    go_a(1'b0, t0);
    tick(66);
    ba.clr_req = 1'b1; tick(1); ba.clr_req = 1'b0;
    tick(3);
    ba.clr_req = 1'b1; tick(1); ba.clr_req = 1'b0;
    wait_fd_a(f0 + 1, 1000);
    n_chk++;
    if (clr_cnt_a - c0 != 1 || clr_fall_a - t0 != 113) begin
      n_fail++; $display("FAIL clear_pulse: got %0d pulses, last at %0d, want 1 at 113", clr_cnt_a - c0, clr_fall_a - t0);
    end
    n_chk++;
    if (fd_cyc_a - t0 != 338) begin n_fail++; $display("FAIL frame_done_clear: got %0d, want 338", fd_cyc_a - t0); end
    tick(8);
    n_chk++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL sb_drain_clear: %0d visits missing, want 0", qa.size()); end
  endtask

  task automatic test_cont();
    int t0, f0;
    f0 = fd_cnt_a;
    go_a(1'b1, t0);
    tick(150);
    wr_a(0, 12'h9A7);
    push_a();
    wait_fd_a(f0 + 1, 1000);
    n_chk++;
    if (fd_cyc_a - t0 != 336 || ba.busy !== 1'b1) begin
      n_fail++; $display("FAIL cont_wrap: got fd at %0d busy=%b, want 336 busy=1", fd_cyc_a - t0, ba.busy);
    end
    ba.cont = 1'b0;
    wait_fd_a(f0 + 2, 1000);
    n_chk++;
    if (fd_cyc_a - t0 != 672 || ba.busy !== 1'b0) begin
      n_fail++; $display("FAIL cont_stop: got fd at %0d busy=%b, want 672 busy=0", fd_cyc_a - t0, ba.busy);
    end
    tick(8);
    n_chk++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL sb_drain_cont: %0d visits missing, want 0", qa.size()); end
  endtask

  task automatic test_reset_mid();
    int t0, l0, c0, f0;
    go_a(1'b0, t0);
    tick(141);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    qa.delete();
    n_chk++;
    if ({ba.dac_clk, ba.dac_sdi, ba.dac_ld_n, ba.dac_clr_n, ba.busy, ba.frame_done, ba.mux_sel} !== 12'b101100_000000) begin
      n_fail++; $display("FAIL reset_mid: got %b, want 101100000000",
        {ba.dac_clk, ba.dac_sdi, ba.dac_ld_n, ba.dac_clr_n, ba.busy, ba.frame_done, ba.mux_sel});
    end
    l0 = ld_cnt_a; c0 = clr_cnt_a;
    tick(60);
    n_chk++;
    if (ld_cnt_a != l0 || clr_cnt_a != c0 || ba.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: got ld=%0d clr=%0d busy=%b, want 0 0 0", ld_cnt_a - l0, clr_cnt_a - c0, ba.busy);
    end
    for (int c = 0; c < 6; c++) ma[c] = 12'h000;
    f0 = fd_cnt_a;
    go_a(1'b0, t0);
    wait_fd_a(f0 + 1, 1000);
    n_chk++;
    if (fd_cyc_a - t0 != 336) begin n_fail++; $display("FAIL frame_after_reset: got %0d, want 336", fd_cyc_a - t0); end
    tick(8);
    n_chk++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL sb_drain_reset: %0d visits missing, want 0", qa.size()); end
  endtask

  task automatic test_wide();
    int t0, f0;
    exp_t e;
    wr_b(0, 16'hA5C3);
    wr_b(1, 16'h1234);
    for (int c = 0; c < 2; c++) begin e.ch = c; e.w = mb[c]; qb.push_back(e); end
    f0 = fd_cnt_b;
    bb.start = 1'b1; bb.cont = 1'b0;
    tick(1);
    t0 = cyc;
    bb.start = 1'b0;
    tick(1);
    n_chk++;
    if ({bb.dac_clk, bb.dac_sdi} !== 2'b01) begin
      n_fail++; $display("FAIL wide_bit0_low: got clk/sdi=%b, want 01", {bb.dac_clk, bb.dac_sdi});
    end
    tick(1);
    n_chk++;
    if ({bb.dac_clk, bb.dac_sdi} !== 2'b11) begin
      n_fail++; $display("FAIL wide_bit0_high: got clk/sdi=%b, want 11", {bb.dac_clk, bb.dac_sdi});
    end
    for (int i = 0; i < 500 && fd_cnt_b == f0; i++) tick(1);
    n_chk++;
    if (fd_cnt_b != f0 + 1 || fd_cyc_b - t0 != 80) begin
      n_fail++; $display("FAIL wide_frame: got count %0d at %0d, want 1 at 80", fd_cnt_b - f0, fd_cyc_b - t0);
    end
    n_chk++;
    if (rise_b - prise_b != 40) begin n_fail++; $display("FAIL wide_period: got %0d, want 40", rise_b - prise_b); end
    tick(8);
    n_chk++;
    if (qb.size() != 0) begin n_fail++; $display("FAIL sb_drain_wide: %0d visits missing, want 0", qb.size()); end
  endtask

  initial begin
    ba.start = 1'b0; ba.cont = 1'b0; ba.clr_req = 1'b0; ba.wr_en = 1'b0; ba.wr_ch = '0; ba.wr_data = '0;
    bb.start = 1'b0; bb.cont = 1'b0; bb.clr_req = 1'b0; bb.wr_en = 1'b0; bb.wr_ch = '0; bb.wr_data = '0;
    for (int c = 0; c < 6; c++) ma[c] = '0;
    for (int c = 0; c < 2; c++) mb[c] = '0;
    test_reset();
    test_single_frame();
    test_bank3();
    test_clear();
    test_cont();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
